// File: rtl/stream_minmax_pkg.sv
// stream_minmax_pkg
//   Shared types and helpers for the stream_minmax frame min/max tracker.
//   - state_t     : frame FSM states (IDLE, ACC, DONE)
//   - WIDTH_DEF   : default sample width
//   - CNT_W_DEF   : default element-counter width
//   - sat_inc()   : increment that sticks at a caller-supplied ceiling
package stream_minmax_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Operands are carried at 32 bits so one function serves any counter
  // width up to 31; callers cast the result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] ceil);
    if (val >= ceil) begin
      return ceil;
    end
    return val + 32'd1;
  endfunction

endpackage

// File: rtl/stream_minmax_cmp_upd.sv
// cmp_upd
//   Combinational compare/update stage for the running min/max.
//   Ports:
//     sample   in  WIDTH  incoming sample
//     cur_min  in  WIDTH  current running minimum
//     cur_max  in  WIDTH  current running maximum
//     nxt_min  out WIDTH  minimum after taking sample into account
//     nxt_max  out WIDTH  maximum after taking sample into account
//     min_upd  out 1      sample is strictly below cur_min
//     max_upd  out 1      sample is strictly above cur_max
//   Strict compares keep the first occurrence when values repeat.
module cmp_upd
  import stream_minmax_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [WIDTH-1:0] cur_min,
  input  logic [WIDTH-1:0] cur_max,
  output logic [WIDTH-1:0] nxt_min,
  output logic [WIDTH-1:0] nxt_max,
  output logic             min_upd,
  output logic             max_upd
);

  always_comb begin
    min_upd = (sample < cur_min);
    max_upd = (sample > cur_max);
    nxt_min = min_upd ? sample : cur_min;
    nxt_max = max_upd ? sample : cur_max;
  end

endmodule

// File: rtl/stream_minmax.sv
// stream_minmax
//   Tracks minimum, maximum and element count of each in_last-framed
//   frame of unsigned samples and presents the result on a held
//   valid/ready port.
//   Ports:
//     clk        in  1      system clock, rising edge
//     rst        in  1      synchronous active-high reset
//     in_valid   in  1      input sample valid
//     in_ready   out 1      block can accept a sample (low while DONE)
//     in_data    in  WIDTH  unsigned sample
//     in_last    in  1      sample closes the frame
//     out_valid  out 1      frame result valid
//     out_ready  in  1      consumer accepts result
//     out_min    out WIDTH  frame minimum
//     out_max    out WIDTH  frame maximum
//     out_count  out CNT_W  element count, saturating at all-ones
//   Optional (STREAM_MINMAX_INDEX_EN defined):
//     out_min_idx out CNT_W  0-based position of first minimum
//     out_max_idx out CNT_W  0-based position of first maximum
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for first beat of a frame; accumulators show old data
//   ACC   | frame open, folding each accepted beat into min/max/count
//   DONE  | result held on out_*; input stalled until out_ready
module stream_minmax
  import stream_minmax_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
`ifdef STREAM_MINMAX_INDEX_EN
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_max_idx,
`endif
  output logic [CNT_W-1:0] out_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t state;
  state_t state_nxt;

  logic             beat;
  logic [WIDTH-1:0] nxt_min;
  logic [WIDTH-1:0] nxt_max;
  logic             min_upd;
  logic             max_upd;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign beat      = in_valid && in_ready;

  assign cnt_inc = CNT_W'(sat_inc(32'(out_count), 32'(CNT_MAX)));

  cmp_upd #(
    .WIDTH(WIDTH)
  ) u_cmp_upd (
    .sample  (in_data),
    .cur_min (out_min),
    .cur_max (out_max),
    .nxt_min (nxt_min),
    .nxt_max (nxt_max),
    .min_upd (min_upd),
    .max_upd (max_upd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (beat) begin
          state_nxt = in_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (beat && in_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Accumulators only move on an accepted beat, and beats are never
  // accepted in DONE, so the result is naturally frozen while held.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_min   <= '0;
      out_max   <= '0;
      out_count <= '0;
    end else if (beat) begin
      if (state == IDLE) begin
        out_min   <= in_data;
        out_max   <= in_data;
        out_count <= CNT_W'(1);
      end else begin
        if (min_upd) begin
          out_min <= nxt_min;
        end
        if (max_upd) begin
          out_max <= nxt_max;
        end
        out_count <= cnt_inc;
      end
    end
  end

`ifdef STREAM_MINMAX_INDEX_EN
  // The position of the current beat equals the number of beats already
  // taken, so out_count doubles as the index source and saturates with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_min_idx <= '0;
      out_max_idx <= '0;
    end else if (beat) begin
      if (state == IDLE) begin
        out_min_idx <= '0;
        out_max_idx <= '0;
      end else begin
        if (min_upd) begin
          out_min_idx <= out_count;
        end
        if (max_upd) begin
          out_max_idx <= out_count;
        end
      end
    end
  end
`endif

endmodule

// File: doc/stream_minmax.md
Name: stream_minmax

Overview:
- Sequential min/max tracker for a stream of unsigned samples, framed by in_last.
- Consumes a valid/ready input stream and reports both minimum and maximum of each frame, plus the element count, on a held valid/ready result port.
- Sits downstream of sample producers in the lab datapath. Its results feed the display/compare stages.

Parameters:
- WIDTH, 8, sample width in bits
- CNT_W, 8, width of element counter; max reportable count is 2^CNT_W-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  WIDTH  unsigned sample
- in_last  in  1  sample is final element of frame
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts result
- out_min  out  WIDTH  minimum of frame
- out_max  out  WIDTH  maximum of frame
- out_count  out  CNT_W  elements in frame, saturating

Behaviour:
- Reset is synchronous, active-high, and sampled on the clk edge. On reset: state=IDLE, out_valid=0, out_min=0, out_max=0, out_count=0. A beat presented in the reset cycle is ignored.
- Beat accepted iff in_valid && in_ready.
- in_ready = (state != DONE), decoded combinationally from state. It is 1 in the first cycle after reset.
- State IDLE:
  - On an accepted beat: out_min=out_max=in_data, out_count=1.
  - Go to DONE if in_last, else go to ACC.
- State ACC, on an accepted beat:
  - out_min updates only if in_data < out_min (strict).
  - out_max updates only if in_data > out_max (strict).
  - out_count increments, saturating at all-ones.
  - Go to DONE if in_last.
- State DONE:
  - out_valid=1. out_min, out_max and out_count are held stable, with no changes while out_valid && !out_ready.
  - On out_ready: out_valid=0 next cycle, go to IDLE.
- Latency: out_valid asserts the cycle after the in_last beat is accepted. The result includes the last beat.
- No overlap between frames: in_ready=0 while in DONE. The minimum gap is one cycle between the in_last beat and the next frame's first beat when out_ready is held high.
- Single-element frame (in_last on the first beat): min=max=that sample, count=1.
- Idle input (in_valid=0) in ACC: state is held, with no change.
- in_data, in_last and in_valid are don't-care when in_ready=0.
- Reset mid-frame or while DONE: the partial or pending result is dropped and the block returns to IDLE.
- Comparisons are unsigned and full WIDTH. Equal values leave min and max unchanged.
- Outside DONE, out_min, out_max and out_count show running accumulators. They are only meaningful when out_valid=1.

Optional Feature:
- Macro: STREAM_MINMAX_INDEX_EN.
- When defined:
  - Adds ports out_min_idx and out_max_idx, each an output of width CNT_W.
  - They give the 0-based frame position of the first occurrence of the min and max.
  - Each index is captured when the corresponding strict update occurs. The first beat sets both to 0.
  - Reset value is 0.
  - The index counter saturates together with out_count.
- When not defined: the ports and registers are absent, and behaviour is otherwise identical.

Decomposition:
- Package stream_minmax_pkg contains:
  - state typedef with IDLE, ACC, DONE
  - default WIDTH and CNT_W constants
  - saturating-increment function
- One natural sub-module: cmp_upd.
  - Combinational.
  - Takes sample, current min and current max.
  - Returns next min, next max, min_upd and max_upd.
  - Instantiated once.

Test Plan:
- Reset then frame 5,3,9,3,7(last) with out_ready=1 -> one cycle after the last beat: out_valid=1, min=3, max=9, count=5. With INDEX_EN: min_idx=1, max_idx=2.
- Single beat 0x80 with last -> min=max=0x80, count=1. The next frame's first beat is accepted two cycles after the last beat.
- Frame 0xFF,0x00(last) with out_ready=0 for 4 cycles -> out_valid and the result are held, in_ready=0 with in_valid asserted and the beat not taken. out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
- Frame 10,20 with in_valid gaps of 3 idle cycles, then rst=1 for one cycle, then frame 4(last) -> result min=max=4, count=1. There is no contamination from the dropped frame.
- CNT_W=2, frame of 5 beats 1,2,3,4,0(last) -> count=3 (saturated), min=0, max=4.
- Equal samples 6,6,6(last) -> min=max=6, count=3. With INDEX_EN: both indices are 0.
